// File: rtl/conf_int_add_accum__seq.sv
`default_nettype none
// ============================================================================
// Module   : conf_int_add_accum__seq
// Brief    : Saturating accumulator for configurable-accuracy adder sums,
//            with approximate-term counting and valid/ready result handshake.
// Revision : 1.0
// ============================================================================
module conf_int_add_accum__seq #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ACC_WIDTH          = 40,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [32:0]          d,
    input  logic                 acc__sel,
    input  logic                 d_valid,
    output logic                 d_ready,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 ovf,
    output logic [CNT_WIDTH-1:0] apx_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf;
    logic [CNT_WIDTH-1:0]   r_apx_cnt;
    logic [CNT_WIDTH-1:0]   r_remaining;
    logic                   w_beat;
    logic [ACC_WIDTH:0]     w_acc_sum;

    generate
        if (ACC_WIDTH < 33 || DATA_PATH_BITWIDTH < 1) begin : g_bad_param
            $error("conf_int_add_accum__seq: ACC_WIDTH must be at least 33");
        end
    endgenerate

    assign w_beat    = (r_state == S_ACC) && d_valid;
    // One extra bit catches the carry-out that triggers saturation.
    assign w_acc_sum = {1'b0, r_acc} + {{(ACC_WIDTH - 32){1'b0}}, d};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (w_beat && (r_remaining == CNT_WIDTH'(1))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (sum_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_apx_cnt   <= '0;
            r_remaining <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_acc       <= '0;
                r_ovf       <= 1'b0;
                r_apx_cnt   <= '0;
                r_remaining <= len;
            end else if (w_beat) begin
                if (w_acc_sum[ACC_WIDTH]) begin
                    r_acc <= '1;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum[ACC_WIDTH-1:0];
                end
                if (!acc__sel && (r_apx_cnt != '1)) begin
                    r_apx_cnt <= r_apx_cnt + CNT_WIDTH'(1);
                end
                r_remaining <= r_remaining - CNT_WIDTH'(1);
            end
        end
    end

    // Result fields come straight from the job registers, which are frozen in DONE.
    assign sum       = r_acc;
    assign ovf       = r_ovf;
    assign apx_cnt   = r_apx_cnt;
    assign d_ready   = (r_state == S_ACC);
    assign sum_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conf_int_add_accum__seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_conf_int_add_accum__seq
// Brief    : Directed scoreboard bench for 40-bit and 33-bit accumulator builds.
// Revision : 1.0
// ============================================================================
module tb_conf_int_add_accum__seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [32:0] d = 33'd0;
    logic        acc__sel = 1'b0;
    logic        d_valid = 1'b0;
    logic        sum_ready = 1'b0;

    logic        d_ready_w, sum_valid_w, ovf_w, busy_w;
    logic [39:0] sum_w;
    logic [7:0]  apx_w;
    logic        d_ready_n, sum_valid_n, ovf_n, busy_n;
    logic [32:0] sum_n;
    logic [7:0]  apx_n;

    always #5 clk = ~clk;

    conf_int_add_accum__seq #(.DATA_PATH_BITWIDTH(16), .ACC_WIDTH(40), .CNT_WIDTH(8)) u_dut_w (
        .clk(clk), .rst(rst), .start(start), .len(len), .d(d), .acc__sel(acc__sel),
        .d_valid(d_valid), .d_ready(d_ready_w), .sum(sum_w), .sum_valid(sum_valid_w),
        .sum_ready(sum_ready), .ovf(ovf_w), .apx_cnt(apx_w), .busy(busy_w)
    );

    conf_int_add_accum__seq #(.DATA_PATH_BITWIDTH(16), .ACC_WIDTH(33), .CNT_WIDTH(8)) u_dut_n (
        .clk(clk), .rst(rst), .start(start), .len(len), .d(d), .acc__sel(acc__sel),
        .d_valid(d_valid), .d_ready(d_ready_n), .sum(sum_n), .sum_valid(sum_valid_n),
        .sum_ready(sum_ready), .ovf(ovf_n), .apx_cnt(apx_n), .busy(busy_n)
    );

    typedef struct {
        logic [39:0] sw;
        logic        ow;
        logic [32:0] sn;
        logic        on;
        logic [7:0]  apx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sum_valid"}, {sum_valid_w, sum_valid_n}, 2'b00);
        chk({tag, "_busy"},      {busy_w, busy_n},           2'b00);
        chk({tag, "_d_ready"},   {d_ready_w, d_ready_n},     2'b00);
    endtask

    // Runs one job from IDLE: model pushes the expected result, the DONE phase pops it.
    task automatic do_job(input int n, input logic [32:0] t[6], input logic s[6],
                          input int gap, input int bp, input bit poke_start);
        exp_t        e;
        logic [40:0] a;
        logic [33:0] b;
        int          lat;
        a = '0; b = '0;
        e.ow = 1'b0; e.on = 1'b0; e.apx = 8'd0;
        for (int i = 0; i < n; i++) begin
            a = {1'b0, a[39:0]} + {8'd0, t[i]};
            if (a[40]) begin a = {1'b0, {40{1'b1}}}; e.ow = 1'b1; end
            b = {1'b0, b[32:0]} + {1'b0, t[i]};
            if (b[33]) begin b = {1'b0, {33{1'b1}}}; e.on = 1'b1; end
            if (!s[i] && e.apx != 8'hFF) e.apx = e.apx + 8'd1;
        end
        e.sw = a[39:0];
        e.sn = b[32:0];
        sb.push_back(e);

        start = 1'b1; len = n[7:0];
        step();
        start = 1'b0; len = 8'hA5;
        chk("busy_after_start", {busy_w, busy_n}, 2'b11);
        chk("d_ready_after_start", {d_ready_w, d_ready_n}, (n != 0) ? 2'b11 : 2'b00);

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                d_valid = 1'b0; d = 33'h1_DEAD_BEEF; acc__sel = 1'b0;
                step();
                chk("d_ready_stall", d_ready_w, 1'b1);
            end
            d_valid = 1'b1; d = t[i]; acc__sel = s[i];
            step();
            d_valid = 1'b0; d = 33'h0_CAFE_F00D;
            if (i < n - 1) chk("d_ready_mid", d_ready_w, 1'b1);
        end

        lat = 0;
        while (!sum_valid_w && lat < 4) begin
            step();
            lat++;
        end
        chk("result_latency", lat, 0);
        chk("sum_valid", {sum_valid_w, sum_valid_n}, 2'b11);
        chk("d_ready_done", {d_ready_w, d_ready_n}, 2'b00);

        e = sb.pop_front();
        chk("sum_w", sum_w, e.sw);
        chk("ovf_w", ovf_w, e.ow);
        chk("apx_w", apx_w, e.apx);
        chk("sum_n", sum_n, e.sn);
        chk("ovf_n", ovf_n, e.on);
        chk("apx_n", apx_n, e.apx);

        for (int k = 0; k < bp; k++) begin
            if (poke_start) begin start = 1'b1; len = 8'd3; end
            step();
            start = 1'b0;
            chk("bp_sum_valid", sum_valid_w, 1'b1);
            chk("bp_sum_stable", sum_w, e.sw);
            chk("bp_apx_stable", apx_w, e.apx);
        end

        sum_ready = 1'b1;
        step();
        sum_ready = 1'b0;
        chk_idle_outputs("after_handshake");
    endtask

    logic [32:0] t[6];
    logic        s[6];

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        step();
        chk_idle_outputs("reset");
        chk("reset_sum", {sum_w, sum_n}, 73'd0);
        chk("reset_ovf_apx", {ovf_w, apx_w, ovf_n, apx_n}, 18'd0);
        step();
        rst = 1'b1;

        // Basic accumulation (33-bit build saturates on the same data)
        t = '{33'h1_0000_0005, 33'h0_0000_000A, 33'h0_FFFF_FFFF, 33'd0, 33'd0, 33'd0};
        s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_job(3, t, s, 0, 0, 1'b0);

        // Approximate counting with stalls
        t = '{33'h0_0000_1234, 33'h1_0000_0000, 33'h0_FFFF_0000, 33'h0_0000_0055, 33'd0, 33'd0};
        s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_job(4, t, s, 2, 0, 1'b0);

        // Saturation
        t = '{33'h1_FFFF_FFFF, 33'h0_0000_0001, 33'd0, 33'd0, 33'd0, 33'd0};
        s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_job(2, t, s, 0, 0, 1'b0);

        // Backpressure with a start poked during DONE, then an immediate follow-on job
        t = '{33'd3, 33'd4, 33'd0, 33'd0, 33'd0, 33'd0};
        s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_job(2, t, s, 0, 5, 1'b1);
        t = '{33'd9, 33'd0, 33'd0, 33'd0, 33'd0, 33'd0};
        s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_job(1, t, s, 0, 0, 1'b0);

        // Zero-length job
        do_job(0, t, s, 0, 0, 1'b0);

        // Reset in the middle of a five-term job
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d_valid = 1'b1; d = 33'h0_0000_0100; acc__sel = 1'b0;
            step();
        end
        d_valid = 1'b0;
        chk("pre_reset_apx", apx_w, 8'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        chk("async_reset_sum", {sum_w, sum_n}, 73'd0);
        chk("async_reset_ovf_apx", {ovf_w, apx_w, ovf_n, apx_n}, 18'd0);
        step();
        step();
        rst = 1'b1;
        t = '{33'd7, 33'd0, 33'd0, 33'd0, 33'd0, 33'd0};
        s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_job(1, t, s, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
